// File: rtl/subr8u_pkg.sv
// Shared types and elaboration helpers for the digit-serial 8-bit subtractor.
package subr8u_pkg;

  localparam int W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SUB   = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic bit digit_w_legal(input int dw);
    return (dw == 1) || (dw == 2) || (dw == 4) || (dw == 8);
  endfunction

  function automatic int num_digits(input int dw);
    return W / dw;
  endfunction

endpackage

// File: rtl/subr8u_serial_chk_if.sv
// Operand/result handshake bundle between producer, subtractor and consumer.
interface subr8u_serial_chk_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] diff;
  logic       borrow;
  logic       err;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, borrow, err
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, borrow, err
  );
endinterface

// File: rtl/subr8u_digit.sv
// Combinational DW-bit borrow-ripple subtract slice: {bout, d} = x - y - bin.
module subr8u_digit #(
  parameter int DW = 2
) (
  input  logic [DW-1:0] x,
  input  logic [DW-1:0] y,
  input  logic          bin,
  output logic [DW-1:0] d,
  output logic          bout
);
  // The extra MSB of the widened difference is the borrow out of this slice.
  assign {bout, d} = {1'b0, x} - {1'b0, y} - {{DW{1'b0}}, bin};
endmodule

// File: rtl/subr8u_serial_chk.sv
// Digit-serial unsigned 8-bit subtractor (diff = a - b, borrow out) with valid/ready
// handshakes. Define SUBR8U_CHECK_EN to add the inverse-addition self-check (err).
module subr8u_serial_chk
  import subr8u_pkg::*;
#(
  parameter int DIGIT_W = 2
) (
  input logic                clk,
  input logic                rst_n,
  subr8u_serial_chk_if.slave bus
);

  localparam int N = num_digits(DIGIT_W);

  if (!digit_w_legal(DIGIT_W)) begin : g_bad_digit_w
    $error("subr8u_serial_chk: DIGIT_W must be 1, 2, 4 or 8");
  end

  state_t         state_q, state_d;
  logic           in_ready_q, in_ready_d;
  logic           out_valid_q, out_valid_d;
  logic [W-1:0]   a_q, b_q, diff_q;
  logic           borrow_q;
  logic [3:0]     cnt_q;
  logic           accept;
  logic           last_digit;
  logic [DIGIT_W-1:0] x, y, d;
  logic           bout;

  assign accept     = bus.in_valid && in_ready_q;
  assign last_digit = (cnt_q == 4'(N - 1));

  // One slice, fed the counter-selected digit of each operand every SUB cycle.
  assign x = a_q[cnt_q*DIGIT_W +: DIGIT_W];
  assign y = b_q[cnt_q*DIGIT_W +: DIGIT_W];

  subr8u_digit #(.DW(DIGIT_W)) u_digit (
    .x    (x),
    .y    (y),
    .bin  (borrow_q),
    .d    (d),
    .bout (bout)
  );

  // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // NOTE: state_d gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = SUB;
      SUB: begin
        if (last_digit) begin
`ifdef SUBR8U_CHECK_EN
          state_d = CHECK;
`else
          state_d = DONE;
`endif
        end
      end
      CHECK:   state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake flags are registered from the next state, so they track the state exactly.
  always_comb begin
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
    end else if (accept) begin
      a_q      <= bus.a;
      b_q      <= bus.b;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
    end else if (state_q == SUB) begin
      diff_q[cnt_q*DIGIT_W +: DIGIT_W] <= d;
      borrow_q <= bout;
      cnt_q    <= cnt_q + 4'd1;
    end
  end

`ifdef SUBR8U_CHECK_EN
  logic [W:0] resum;
  logic       err_q;

  // Adding b back to the difference must reproduce a, with the carry equal to the borrow.
  assign resum = {1'b0, diff_q} + {1'b0, b_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= 1'b0;
    end else if (state_q == CHECK) begin
      err_q <= (resum[W-1:0] != a_q) || (resum[W] != borrow_q);
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.diff      = diff_q;
  assign bus.borrow    = borrow_q;

endmodule

// File: tb/tb_subr8u_serial_chk.sv
// Directed self-checking bench for subr8u_serial_chk (DIGIT_W=2 main instance plus
// DIGIT_W=1/4/8 latency instances). Expectations follow SUBR8U_CHECK_EN when defined.
module tb_subr8u_serial_chk;
  import subr8u_pkg::*;

`ifdef SUBR8U_CHECK_EN
  localparam int EXTRA     = 2;
  localparam int FAULT_ERR = 1;
`else
  localparam int EXTRA     = 1;
  localparam int FAULT_ERR = 0;
`endif
  localparam int LAT2 = 4 + EXTRA;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  subr8u_serial_chk_if bus ();
  subr8u_serial_chk_if bus1 ();
  subr8u_serial_chk_if bus4 ();
  subr8u_serial_chk_if bus8 ();

  subr8u_serial_chk #(.DIGIT_W(2)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  subr8u_serial_chk #(.DIGIT_W(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  subr8u_serial_chk #(.DIGIT_W(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  subr8u_serial_chk #(.DIGIT_W(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  logic       aux_valid, aux_ready;
  logic [7:0] aux_a, aux_b;
  assign bus1.in_valid = aux_valid;  assign bus1.a = aux_a;
  assign bus1.b = aux_b;             assign bus1.out_ready = aux_ready;
  assign bus4.in_valid = aux_valid;  assign bus4.a = aux_a;
  assign bus4.b = aux_b;             assign bus4.out_ready = aux_ready;
  assign bus8.in_valid = aux_valid;  assign bus8.a = aux_a;
  assign bus8.b = aux_b;             assign bus8.out_ready = aux_ready;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns at the sample point just after the accept edge (cycle 1 after accept).
  task automatic send(input logic [7:0] av, input logic [7:0] bv);
    int k;
    k = 0;
    while (!bus.in_ready && k < 30) begin
      tick();
      k++;
    end
    if (!bus.in_ready) check("send_ready_timeout", 0, 1);
    bus.in_valid = 1'b1;
    bus.a        = av;
    bus.b        = bv;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic take(input string tag);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, "_ov_fall"}, int'(bus.out_valid), 0);
    check({tag, "_ir_rise"}, int'(bus.in_ready), 1);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    int         diff;
    int         borrow;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int lat, l1, l4, l8, stable, ovs;
    logic [7:0] flipped;

    vecs[0] = '{8'd200, 8'd55,  145, 0};
    vecs[1] = '{8'd5,   8'd10,  251, 1};
    vecs[2] = '{8'd0,   8'd0,   0,   0};
    vecs[3] = '{8'd255, 8'd255, 0,   0};
    vecs[4] = '{8'd0,   8'd255, 1,   1};
    vecs[5] = '{8'd100, 8'd30,  70,  0};
    vecs[6] = '{8'hAA,  8'h55,  85,  0};
    vecs[7] = '{8'h55,  8'hAA,  171, 1};

    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.out_ready = 1'b0;
    aux_valid = 1'b0; aux_a = '0; aux_b = '0; aux_ready = 1'b0;

    // Reset state, before and across clock edges.
    #2;
    check("rst_in_ready",  int'(bus.in_ready),  0);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_diff",      int'(bus.diff),      0);
    check("rst_borrow",    int'(bus.borrow),    0);
    check("rst_err",       int'(bus.err),       0);
    tick(); tick();
    check("rst_hold_in_ready", int'(bus.in_ready), 0);
    #3 rst_n = 1'b1;
    #1 check("rel_in_ready_pre_edge", int'(bus.in_ready), 0);
    tick();
    check("rel_in_ready_first_edge", int'(bus.in_ready), 1);

    // Directed vectors on the DIGIT_W=2 instance.
    foreach (vecs[i]) begin
      send(vecs[i].a, vecs[i].b);
      wait_result(lat);
      check($sformatf("v%0d_latency", i), lat, LAT2);
      check($sformatf("v%0d_diff", i),    int'(bus.diff),   vecs[i].diff);
      check($sformatf("v%0d_borrow", i),  int'(bus.borrow), vecs[i].borrow);
      check($sformatf("v%0d_err", i),     int'(bus.err),    0);
      take($sformatf("v%0d", i));
    end

    // a=5, b=10 on DIGIT_W=1/4/8 in parallel.
    aux_valid = 1'b1; aux_a = 8'd5; aux_b = 8'd10;
    tick();
    aux_valid = 1'b0;
    l1 = 0; l4 = 0; l8 = 0;
    for (int k = 1; k <= 20; k++) begin
      if (bus1.out_valid && l1 == 0) l1 = k;
      if (bus4.out_valid && l4 == 0) l4 = k;
      if (bus8.out_valid && l8 == 0) l8 = k;
      tick();
    end
    check("dw1_latency", l1, 8 + EXTRA);
    check("dw4_latency", l4, 2 + EXTRA);
    check("dw8_latency", l8, 1 + EXTRA);
    check("dw1_diff", int'(bus1.diff), 251);
    check("dw4_diff", int'(bus4.diff), 251);
    check("dw8_diff", int'(bus8.diff), 251);
    check("dw1_borrow", int'(bus1.borrow), 1);
    check("dw4_borrow", int'(bus4.borrow), 1);
    check("dw8_borrow", int'(bus8.borrow), 1);
    check("dw1_err", int'(bus1.err), 0);
    check("dw8_err", int'(bus8.err), 0);
    aux_ready = 1'b1;
    tick();
    aux_ready = 1'b0;
    check("dw1_ready_after", int'(bus1.in_ready), 1);
    check("dw8_ready_after", int'(bus8.in_ready), 1);

    // Back-pressure: DONE held 20 cycles while a new request waits.
    send(8'd150, 8'd20);
    wait_result(lat);
    check("bp_latency", lat, LAT2);
    bus.in_valid = 1'b1; bus.a = 8'd9; bus.b = 8'd4;
    stable = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus.out_valid && !bus.in_ready && bus.diff == 8'd130 && !bus.borrow) stable++;
    end
    check("bp_stable_cycles", stable, 20);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("bp_release_ov", int'(bus.out_valid), 0);
    check("bp_release_ir", int'(bus.in_ready),  1);
    tick();
    bus.in_valid = 1'b0;
    check("bp_second_accepted", int'(bus.in_ready), 0);
    wait_result(lat);
    check("bp_second_latency", lat, LAT2);
    check("bp_second_diff",    int'(bus.diff),   5);
    check("bp_second_borrow",  int'(bus.borrow), 0);
    take("bp_second");

    // Reset pulse while digit 2 is being processed.
    send(8'd77, 8'd33);
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    check("midrst_in_ready",  int'(bus.in_ready),  0);
    check("midrst_out_valid", int'(bus.out_valid), 0);
    check("midrst_diff",      int'(bus.diff),      0);
    check("midrst_borrow",    int'(bus.borrow),    0);
    check("midrst_err",       int'(bus.err),       0);
    #1 rst_n = 1'b1;
    #1 check("midrst_ir_pre_edge", int'(bus.in_ready), 0);
    tick();
    check("midrst_ir_after_edge", int'(bus.in_ready), 1);
    ovs = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (bus.out_valid) ovs++;
    end
    check("midrst_no_stale_result", ovs, 0);

    // Fault injection: flip diff bit 3 once SUB has finished.
    send(8'd100, 8'd30);
    lat = 0;
    while (dut.state_q == SUB && lat < 20) begin
      tick();
      lat++;
    end
    flipped = dut.diff_q ^ 8'h08;
    force dut.diff_q = flipped;
    tick();
    release dut.diff_q;
    wait_result(lat);
    check("fault_out_valid", int'(bus.out_valid), 1);
    check("fault_err",       int'(bus.err),       FAULT_ERR);
    take("fault");

    // Clean run afterwards clears err.
    send(8'd100, 8'd30);
    wait_result(lat);
    check("post_fault_diff", int'(bus.diff), 70);
    check("post_fault_err",  int'(bus.err),  0);
    take("post_fault");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/subr8u_serial_chk.md
# subr8u_serial_chk

Multi-cycle unsigned 8-bit subtractor with a valid/ready handshake and an optional inverse-addition self-check. It is the inverse-direction counterpart to the gate-level 8-bit unsigned adders: it computes D = A − B with borrow-out in digit-serial fashion. When the check is compiled in, it re-adds B to D to detect faults in the datapath. It sits between an operand producer and a result consumer in the fault-resilient arithmetic test harnesses.

## Interface
- DIGIT_W, 2, bits processed per SUB cycle; legal values 1, 2, 4, 8
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operands a/b valid
- in_ready  output  1  block can accept operands
- a  input  8  minuend, unsigned
- b  input  8  subtrahend, unsigned
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- diff  output  8  (a − b) mod 256
- borrow  output  1  1 when a < b
- err  output  1  self-check mismatch; meaningful only while out_valid=1

## Operation
- FSM states: IDLE, SUB, CHECK, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, capture a and b into registers, clear the digit counter and borrow, and go to SUB.
- SUB: each cycle processes digit k (bits k·DIGIT_W … k·DIGIT_W+DIGIT_W−1, LSB first).
  - diff slice = a slice − b slice − borrow_in.
  - borrow_out is registered as borrow_in for digit k+1.
  - After N = 8/DIGIT_W cycles, go to CHECK if SUBR8U_CHECK_EN is defined, else go to DONE.
- CHECK (one cycle): compute the 9-bit sum {c, s} = diff + b_reg.
  - err = (s != a_reg) || (c != borrow).
  - Go to DONE.
- DONE: out_valid=1, and diff/borrow/err are stable. On out_ready, go to IDLE.
- Inputs a/b are ignored outside the accept cycle. Operands are held internally, so the producer may change them after the handshake.
- Width rules: diff wraps modulo 256. borrow is the final borrow of the MSB digit.
- Illegal DIGIT_W values trigger an elaboration-time error.

## Timing
- Reset values (asserted asynchronously, held while rst_n=0):
  - State is IDLE.
  - in_ready, out_valid, diff, borrow, err are all 0.
  - in_ready rises on the first clk edge after rst_n deasserts.
- in_ready and out_valid are registered. in_ready=1 exactly in IDLE; out_valid=1 exactly in DONE.
- Latency from the accept edge to out_valid=1:
  - N+2 cycles with the check compiled in (DIGIT_W=2: 6 cycles).
  - N+1 cycles without it.
- Back-pressure: while out_ready=0, DONE holds indefinitely with all outputs stable.
- Result handshake: on the out_ready edge, out_valid falls and in_ready rises in the same cycle.
  - No same-cycle result/accept overlap; the minimum issue interval is N+3 cycles (with check).
- in_valid asserted while in_ready=0 is ignored. The producer must hold it until it is accepted.
- Reset mid-operation (any state): abort immediately. No stale result or err is emitted after reset.
- Zero operands and equal operands are not special cases; they take the full latency.

## Configuration
- SUBR8U_CHECK_EN defined:
  - CHECK state and its 8-bit adder are instantiated.
  - err is driven as above.
- SUBR8U_CHECK_EN undefined:
  - No CHECK state; SUB goes directly to DONE.
  - err is tied to 0.
  - Latency is N+1.

## Structure
- Package subr8u_pkg holds:
  - the state enum (IDLE, SUB, CHECK, DONE);
  - the operand width constant W=8;
  - the legal-DIGIT_W check function;
  - a function returning N = W/DIGIT_W.
- Sub-module subr8u_digit: combinational DIGIT_W-bit borrow-ripple slice.
  - Ports: x, y, bin, d, bout.
  - Instantiated once and reused each SUB cycle through counter-indexed operand muxing.

## Test plan
- a=200, b=55, DIGIT_W=2 → diff=145, borrow=0, err=0, out_valid exactly 6 cycles after accept.
- a=5, b=10 → diff=251, borrow=1, err=0. Repeat for DIGIT_W=1, 4, 8 with latencies 10, 4, 3 cycles.
- a=0, b=0 and a=255, b=255 → diff=0, borrow=0. Then a=0, b=255 → diff=1, borrow=1.
- out_ready held 0 for 20 cycles in DONE → diff/borrow/out_valid stable and in_valid ignored. Release → in_ready=1 in the next cycle, and a second operand pair is accepted.
- rst_n pulsed low during SUB (digit 2) → all outputs 0 immediately, in_ready=1 one edge after release, and no out_valid follows.
- With SUBR8U_CHECK_EN, force bit 3 of the internal diff register to flip after SUB for a=100, b=30 → err=1 in DONE. Without the macro, the same force gives err=0.
